// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end with prefetch queue and redirect flush
// Responses are matched to issue PCs through a tag FIFO; redirects drop every unreturned fetch.
module fetch_unit #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            start_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [INSTR_W-1:0]           imem_rdata,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]      tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;

    logic [INSTR_W-1:0] q_instr_mem [DEPTH];
    logic [ADDR_W-1:0]  q_pc_mem    [DEPTH];
    logic [ADDR_W-1:0]  tag_mem     [DEPTH];

    logic [CW:0]        budget;
    logic               accept, rsp, push, pop;

    // Issue credit uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign budget      = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req    = rst_n && !redirect && (budget < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_gnt;
    assign rsp         = imem_rvalid && (inflight_q != '0);
    assign push        = rsp && (drop_q == '0) && !redirect;
    assign instr_valid = (count_q != '0) && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr       = q_instr_mem[head_q];
    assign instr_pc    = q_pc_mem[head_q];
    assign occupancy   = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_head_d = tag_head_q;
        tag_tail_d = tag_tail_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(accept) - CW'(rsp);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            tag_tail_d = ptr_inc(tag_tail_q);
        end
        if (rsp) begin
            tag_head_d = ptr_inc(tag_head_q);
        end
        if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        // A response landing in the redirect cycle is already removed from inflight_d.
        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc;
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= start_pc;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_head_q <= tag_head_d;
            tag_tail_q <= tag_tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_tail_q] <= fetch_pc_q;
        end
        if (rst_n && push) begin
            q_instr_mem[tail_q] <= imem_rdata;
            q_pc_mem[tail_q]    <= tag_mem[tag_head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (budget <= (CW+1)'(DEPTH));
            assert (drop_q <= inflight_q);
            assert (!(push && (count_q == CW'(DEPTH))));
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against an epoch-based stream model
module tb_fetch_unit;
    localparam int AW    = 11;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] start_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [CW-1:0] occupancy;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
        int            epoch;
    } pend_t;

    pend_t         pend[$];
    int            cyc, epoch, mcount;
    logic [AW-1:0] fpc, exp_pc;
    int            gnt_mode, rdy_mode, lat_min, lat_max;
    bit            force_rv;
    int            n_checks, n_pass, n_fail;
    bit            obs_req, obs_valid, obs_acc;
    int            obs_occ;
    logic [AW-1:0] obs_addr;
    bit            seen_first;
    logic [AW-1:0] first_pc;
    int            nv, na;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare after settle, then advance the model past the posedge.
    task automatic step(input bit redir, input logic [AW-1:0] rpc);
        bit    rv, exp_req, exp_valid, acc, pop;
        pend_t e;
        @(negedge clk);
        rst_n       = 1'b1;
        redirect    = redir;
        redirect_pc = rpc;
        imem_gnt    = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
        instr_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
        rv          = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid = rv || force_rv;
        imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom();
        #1;
        exp_req   = !redir && (mcount + pend.size() < DEPTH);
        exp_valid = (mcount > 0) && !redir;
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, fpc);
        chk("instr_valid", instr_valid, exp_valid);
        chk("occupancy", occupancy, mcount);
        if (exp_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, mem_word(exp_pc));
        end
        obs_req   = imem_req;
        obs_valid = instr_valid;
        obs_acc   = imem_req && imem_gnt;
        obs_occ   = int'(occupancy);
        obs_addr  = imem_addr;
        if (instr_valid && !seen_first) begin
            seen_first = 1'b1;
            first_pc   = instr_pc;
        end
        acc = exp_req && imem_gnt;
        pop = exp_valid && instr_ready;
        @(posedge clk);
        if (pop) begin
            mcount--;
            exp_pc++;
        end
        if (rv) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) mcount++;
        end
        if (acc) begin
            pend.push_back('{fpc, cyc + int'($urandom_range(lat_min, lat_max)), epoch});
            fpc++;
        end
        if (redir) begin
            mcount = 0;
            epoch++;
            fpc    = rpc;
            exp_pc = rpc;
        end
        cyc++;
    endtask

    task automatic do_reset(input logic [AW-1:0] spc, input bit rv_in_reset);
        @(negedge clk);
        rst_n       = 1'b0;
        start_pc    = spc;
        redirect    = 1'b0;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        imem_rvalid = rv_in_reset;
        imem_rdata  = $urandom();
        #1;
        chk("req_in_reset", imem_req, 1'b0);
        @(posedge clk);
        cyc++;
        pend.delete();
        mcount = 0;
        fpc    = spc;
        exp_pc = spc;
        epoch++;
    endtask

    initial begin
        rst_n = 1'b0; start_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        cyc = 0; epoch = 0; mcount = 0; fpc = '0; exp_pc = '0;
        n_checks = 0; n_pass = 0; n_fail = 0; force_rv = 1'b0;
        gnt_mode = 1; rdy_mode = 1; lat_min = 1; lat_max = 1;

        // Streaming at one instruction per cycle once the pipe has filled.
        do_reset(11'h010, 1'b0);
        seen_first = 1'b0;
        repeat (2) step(1'b0, '0);
        nv = 0;
        repeat (8) begin step(1'b0, '0); nv += int'(obs_valid); end
        chk("t1_rate", nv, 8);
        chk("t1_first_pc", first_pc, 11'h010);

        // Backpressure: exactly DEPTH accepts, then reissue one cycle after the first pop.
        do_reset(11'h020, 1'b0);
        rdy_mode = 0;
        na = 0;
        repeat (10) begin step(1'b0, '0); na += int'(obs_acc); end
        chk("t2_accepts", na, 4);
        chk("t2_req_off", obs_req, 1'b0);
        chk("t2_occ", obs_occ, 4);
        rdy_mode = 1;
        step(1'b0, '0);
        chk("t2_req_pop_cycle", obs_req, 1'b0);
        step(1'b0, '0);
        chk("t2_req_reassert", obs_req, 1'b1);
        repeat (10) step(1'b0, '0);

        // Redirect with three slow fetches outstanding.
        do_reset(11'h030, 1'b0);
        lat_min = 4; lat_max = 4;
        repeat (3) step(1'b0, '0);
        step(1'b1, 11'h100);
        seen_first = 1'b0;
        repeat (16) step(1'b0, '0);
        chk("t3_first_pc", first_pc, 11'h100);

        // Redirect colliding with a response and a ready consumer.
        do_reset(11'h040, 1'b0);
        lat_min = 1; lat_max = 1;
        repeat (4) step(1'b0, '0);
        step(1'b1, 11'h2A0);
        step(1'b0, '0);
        chk("t4_occ", obs_occ, 0);
        chk("t4_addr", obs_addr, 11'h2A0);
        repeat (6) step(1'b0, '0);

        // PC wrap at the top of the address space.
        do_reset(11'h7FE, 1'b0);
        repeat (2) step(1'b0, '0);
        nv = 0;
        repeat (6) begin step(1'b0, '0); nv += int'(obs_valid); end
        chk("t5_wrap_rate", nv, 6);

        // Reset with responses outstanding; a late response must be ignored.
        lat_min = 3; lat_max = 3;
        do_reset(11'h060, 1'b0);
        repeat (5) step(1'b0, '0);
        do_reset(11'h055, 1'b1);
        force_rv = 1'b1; gnt_mode = 0;
        step(1'b0, '0);
        force_rv = 1'b0; gnt_mode = 1;
        step(1'b0, '0);
        chk("t6_occ", obs_occ, 0);
        chk("t6_valid", obs_valid, 1'b0);
        chk("t6_addr", obs_addr, 11'h055);
        repeat (10) step(1'b0, '0);

        // Randomized grant, ready, latency and redirects.
        gnt_mode = 2; rdy_mode = 2; lat_min = 1; lat_max = 5;
        repeat (2000) begin
            if ($urandom_range(0, 11) == 0) step(1'b1, AW'($urandom()));
            else step(1'b0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
